// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch->decode pipeline register.
//   PC_W_DEF / INSTR_W_DEF : default field widths
//   NOP_INSTR              : bubble encoding at the default instruction width
//   slot_t                 : {valid, pc, instr} view of one storage slot
//   occ_count()            : number of valid slots out of two
package pipe_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic                   valid;
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } slot_t;

  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot (valid + PC + instruction) of the IF/ID skid register.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   flush_i       : drop the entry; valid->0, instr->NOP, PC kept
//   load_i        : capture pc_i/instr_i and mark valid
//   clr_vld_i     : entry consumed; valid->0, PC/instr kept
//   pc_i, instr_i : data to load
//   valid_o, pc_o, instr_o : registered slot contents
// Priority: flush > load > clr_vld > hold.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                  PC_W      = PC_W_DEF,
  parameter int                  INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0]  NOP_VALUE = {INSTR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic               clr_vld_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      // PC is left alone so the decode side still sees the last head PC.
      valid_d = 1'b0;
      instr_d = NOP_VALUE;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (clr_vld_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_VALUE;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_stage_skid_reg.sv
// IF/ID pipeline register with valid/ready handshakes and a 2-entry skid
// buffer, plus freeze (hazard stall) and flush (taken branch) controls.
// Ports:
//   clk, reset          : clock, async active-low reset
//   freeze              : hold all state, block both handshakes
//   flush               : discard held and incoming entries
//   in_valid/in_ready   : fetch-side handshake, pc_in/instr_in payload
//   out_valid/out_ready : decode-side handshake, pc_out/instr_out payload
//   occupancy           : held entries, 0..2
// The main slot is the head and drives the outputs; the skid slot only
// fills when decode stalls while fetch delivers.
module if_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_VALUE = {INSTR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               freeze,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [1:0]         occupancy
);

  logic               m_vld, s_vld;
  logic [PC_W-1:0]    m_pc, s_pc;
  logic [INSTR_W-1:0] m_instr, s_instr;

  logic               accept, drain;
  logic               m_load, m_clr, s_load, s_clr;
  logic [PC_W-1:0]    m_pc_src;
  logic [INSTR_W-1:0] m_instr_src;

  // reset gates in_ready so fetch never handshakes while we are held in reset.
  assign in_ready = reset & ~s_vld & ~freeze & ~flush;
  assign accept   = in_valid & in_ready;
  assign drain    = m_vld & out_ready & ~freeze & ~flush;

  // Freeze needs no explicit term: it forces accept=drain=0, so every
  // load/clear below stays low and both slots hold.
  always_comb begin
    m_load      = 1'b0;
    m_clr       = 1'b0;
    s_load      = 1'b0;
    s_clr       = 1'b0;
    m_pc_src    = pc_in;
    m_instr_src = instr_in;
    if (drain && s_vld) begin
      // Full: head leaves, skid entry moves up. accept is impossible here.
      m_load      = 1'b1;
      m_pc_src    = s_pc;
      m_instr_src = s_instr;
      s_clr       = 1'b1;
    end else if (accept && (!m_vld || drain)) begin
      // Empty, or pass-through while the head drains.
      m_load = 1'b1;
    end else if (accept) begin
      // Head stalled by decode: park the new entry in the skid slot.
      s_load = 1'b1;
    end else if (drain) begin
      m_clr = 1'b1;
    end
  end

  pipe_slot #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_VALUE (NOP_VALUE)
  ) u_main (
    .clk       (clk),
    .rst_n     (reset),
    .flush_i   (flush),
    .load_i    (m_load),
    .clr_vld_i (m_clr),
    .pc_i      (m_pc_src),
    .instr_i   (m_instr_src),
    .valid_o   (m_vld),
    .pc_o      (m_pc),
    .instr_o   (m_instr)
  );

  pipe_slot #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_VALUE (NOP_VALUE)
  ) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .flush_i   (flush),
    .load_i    (s_load),
    .clr_vld_i (s_clr),
    .pc_i      (pc_in),
    .instr_i   (instr_in),
    .valid_o   (s_vld),
    .pc_o      (s_pc),
    .instr_o   (s_instr)
  );

  assign out_valid = m_vld;
  assign pc_out    = m_pc;
  // Decode sees a bubble whenever the head is empty, regardless of stale data.
  assign instr_out = m_vld ? m_instr : NOP_VALUE;
  assign occupancy = occ_count(m_vld, s_vld);

  // A valid skid entry behind an empty head would reorder traffic.
  a_no_orphan_skid: assert property (@(posedge clk) disable iff (!reset)
    !(!m_vld && s_vld));

  // Only one slot may be written from the fetch side per cycle.
  a_single_load: assert property (@(posedge clk) disable iff (!reset)
    !(s_load && m_load));

endmodule

// File: tb/tb_if_stage_skid_reg.sv
module tb_if_stage_skid_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset, freeze, flush, in_valid, out_ready;
  logic [31:0] pc_in, instr_in;
  logic        in_ready, out_valid;
  logic [31:0] pc_out, instr_out;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;

  // Reference model: an in-order FIFO of at most two entries.
  slot_t       mq[$];
  logic [31:0] m_last_pc;

  if_stage_skid_reg dut (
    .clk       (clk),
    .reset     (reset),
    .freeze    (freeze),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update: reset wins immediately, then flush, then freeze.
  initial begin
    m_last_pc = '0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mq.delete();
        m_last_pc = '0;
      end else if (flush) begin
        mq.delete();
      end else if (!freeze) begin
        automatic bit dr = (mq.size() > 0) && out_ready;
        automatic bit ac = in_valid && (mq.size() < 2);
        if (dr) void'(mq.pop_front());
        if (ac) mq.push_back('{valid: 1'b1, pc: pc_in, instr: instr_in});
        if (mq.size() > 0) m_last_pc = mq[0].pc;
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("m_pc_out",    64'(pc_out),    64'(m_last_pc));
      chk("m_instr_out", 64'(instr_out), (mq.size() > 0) ? 64'(mq[0].instr) : 64'(NOP_INSTR));
      chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
      chk("m_in_ready",  64'(in_ready),
          64'(reset && (mq.size() < 2) && !freeze && !flush));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic frz, input logic fl);
    in_valid  = v;
    pc_in     = pc;
    instr_in  = ins;
    out_ready = ordy;
    freeze    = frz;
    flush     = fl;
  endtask

  initial begin
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_pc_out",    64'(pc_out),    0);
    chk("rst_instr_out", 64'(instr_out), 0);
    chk("rst_occupancy", 64'(occupancy), 0);
    chk("rst_in_ready",  64'(in_ready),  0);
    step(); step();
    reset = 1'b1;

    // Fill to two entries, then reset mid-stream.
    drv(1, 32'h100, 32'h11, 0, 0, 0); step();
    drv(1, 32'h104, 32'h22, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_occ", 64'(occupancy), 2);
    chk("full_in_ready", 64'(in_ready), 0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_instr",     64'(instr_out), 0);
    chk("midrst_pc",        64'(pc_out),    0);
    chk("midrst_occ",       64'(occupancy), 0);
    step();
    reset = 1'b1;

    // First accept after reset, then streaming.
    drv(1, 32'h4, 32'hE3A01005, 1, 0, 0); step();
    chk("first_valid", 64'(out_valid), 1);
    chk("first_pc",    64'(pc_out),    32'h4);
    chk("first_instr", 64'(instr_out), 32'hE3A01005);
    drv(1, 32'h8, 32'hA, 1, 0, 0); step();
    chk("stream_pc8", 64'(pc_out), 32'h8);
    chk("stream_rdy", 64'(in_ready), 1);
    drv(1, 32'hC, 32'hB, 1, 0, 0); step();
    chk("stream_pcC", 64'(pc_out), 32'hC);
    drv(0, 0, 0, 1, 0, 0); step();
    chk("empty_valid", 64'(out_valid), 0);
    chk("empty_pc",    64'(pc_out),    32'hC);
    chk("empty_instr", 64'(instr_out), 0);

    // Back-pressure.
    drv(1, 32'h10, 32'h10, 0, 0, 0); step();
    drv(1, 32'h14, 32'h14, 0, 0, 0); step();
    drv(1, 32'h18, 32'h18, 0, 0, 0); step();
    chk("bp_occ",   64'(occupancy), 2);
    chk("bp_rdy",   64'(in_ready),  0);
    chk("bp_head",  64'(pc_out),    32'h10);
    out_ready = 1'b1; step();
    chk("bp_pc14",  64'(pc_out),    32'h14);
    step();
    chk("bp_pc18",  64'(pc_out),    32'h18);
    chk("bp_occ1",  64'(occupancy), 1);
    drv(0, 0, 0, 1, 0, 0); step();

    // Freeze with one entry held.
    drv(1, 32'h30, 32'h30, 0, 0, 0); step();
    drv(1, 32'h34, 32'h34, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_pc",  64'(pc_out),    32'h30);
      chk("frz_occ", 64'(occupancy), 1);
      chk("frz_rdy", 64'(in_ready),  0);
    end
    drv(0, 0, 0, 1, 0, 0); step();
    chk("frz_drained", 64'(out_valid), 0);

    // Flush at occupancy 2 with an offered entry.
    drv(1, 32'h40, 32'h40, 0, 0, 0); step();
    drv(1, 32'h44, 32'h44, 0, 0, 0); step();
    drv(1, 32'h20, 32'h20, 0, 0, 1);
    #1 chk("fl_rdy", 64'(in_ready), 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    chk("fl_valid", 64'(out_valid), 0);
    chk("fl_instr", 64'(instr_out), 0);
    chk("fl_occ",   64'(occupancy), 0);
    chk("fl_pc",    64'(pc_out),    32'h40);

    // Flush and freeze together.
    drv(1, 32'h50, 32'h50, 0, 0, 0); step();
    drv(0, 0, 0, 0, 1, 1); step();
    chk("flfrz_occ", 64'(occupancy), 0);

    // Accept and drain together at occupancy 1.
    drv(1, 32'h60, 32'h60, 0, 0, 0); step();
    drv(1, 32'h64, 32'h64, 1, 0, 0); step();
    chk("ad_occ", 64'(occupancy), 1);
    chk("ad_pc",  64'(pc_out),    32'h64);
    drv(0, 0, 0, 1, 0, 0); step();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(99) != 0);
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      freeze    = ($urandom_range(9) == 0);
      flush     = ($urandom_range(19) == 0);
      pc_in     = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
      instr_in  = $urandom;
      step();
    end
    reset = 1'b1;
    drv(0, 0, 0, 1, 0, 0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
